// File: rtl/arc4_pkg.sv
// Shared ARC4 types and helpers: S-box geometry, key-schedule FSM states, key byte selection.
package arc4_pkg;

    localparam int SBOX_SIZE     = 256;
    localparam int KEY_MAX_BYTES = 32;
    localparam int KEY_MAX_W     = 8 * KEY_MAX_BYTES;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_I  = 3'd1,
        CAP_I = 3'd2,
        RD_J  = 3'd3,
        CAP_J = 3'd4,
        WR_I  = 3'd5,
        WR_J  = 3'd6
    } ksa_state_e;

    // Key is right-aligned in a KEY_MAX_W container; byte 0 is the most significant of nbytes.
    function automatic logic [7:0] key_byte(input logic [KEY_MAX_W-1:0] key,
                                            input int unsigned          nbytes,
                                            input int unsigned          idx);
        logic [KEY_MAX_W-1:0] sh;
        sh = key >> (8 * (nbytes - 1 - idx));
        return sh[7:0];
    endfunction

endpackage

// File: rtl/ksa_if.sv
// Start/done handshake, key and S-memory bus of the key-scheduling stage.
interface ksa_if #(
    parameter int KEY_BYTES = 3,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8
);
    logic                   en;
    logic                   rdy;
    logic [8*KEY_BYTES-1:0] key;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_W-1:0]      rddata;
    logic [DATA_W-1:0]      wrdata;
    logic                   wren;

    modport master (input en, key, rddata, output rdy, addr, wrdata, wren);
    modport slave  (output en, key, rddata, input rdy, addr, wrdata, wren);
endinterface

// File: rtl/ksa.sv
// ARC4 key schedule over an external 256x8 S memory: j += S[i] + key[i mod n]; swap(S[i], S[j]).
// Latency 1536 cycles (6 per i) from accepted en to rdy; en is accepted only while rdy=1,
// and en while busy is dropped, not queued.
module ksa
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    ksa_if.master bus
);

    localparam int                KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
    localparam logic [ADDR_W-1:0] I_LAST    = ADDR_W'(SBOX_SIZE - 1);

    ksa_state_e             state_q, state_d;
    logic [ADDR_W-1:0]      i_q, i_d;
    logic [DATA_W-1:0]      j_q, j_d;
    logic [DATA_W-1:0]      si_q, si_d;
    logic [DATA_W-1:0]      sj_q, sj_d;
    logic [KIDX_W-1:0]      kidx_q, kidx_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [7:0]             kbyte;

    assign kbyte = key_byte(KEY_MAX_W'(key_q), KEY_BYTES, 32'(kidx_q));

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        si_d       = si_q;
        sj_d       = sj_q;
        kidx_d     = kidx_q;
        key_d      = key_q;
        bus.rdy    = 1'b0;
        bus.addr   = '0;
        bus.wrdata = '0;
        bus.wren   = 1'b0;

        case (state_q)
            IDLE: begin
                bus.rdy = 1'b1;
                if (bus.en) begin
                    key_d   = bus.key;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    state_d = RD_I;
                end
            end
            RD_I: begin
                bus.addr = i_q;
                state_d  = CAP_I;
            end
            CAP_I: begin
                si_d    = bus.rddata;
                j_d     = j_q + bus.rddata + DATA_W'(kbyte);
                state_d = RD_J;
            end
            RD_J: begin
                bus.addr = ADDR_W'(j_q);
                state_d  = CAP_J;
            end
            CAP_J: begin
                sj_d    = bus.rddata;
                state_d = WR_I;
            end
            WR_I: begin
                bus.addr   = i_q;
                bus.wrdata = sj_q;
                bus.wren   = 1'b1;
                state_d    = WR_J;
            end
            WR_J: begin
                // When i==j, si==sj, so this second write rewrites the same value.
                bus.addr   = ADDR_W'(j_q);
                bus.wrdata = si_q;
                bus.wren   = 1'b1;
                i_d        = i_q + 1'b1;
                kidx_d     = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
                state_d    = (i_q == I_LAST) ? IDLE : RD_I;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            kidx_q  <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
            key_q   <= key_d;
        end
    end

endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: S memory model, software KSA scoreboard of expected writes, final S-box compare.
module tb_ksa;

    logic clk = 1'b0;
    logic rst_n;
    logic init_req;
    logic mon_on;

    always #5 clk = ~clk;

    ksa_if #(.KEY_BYTES(3), .ADDR_W(8), .DATA_W(8)) bus ();

    ksa #(.KEY_BYTES(3), .ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]  mem [256];
    logic [7:0]  gs  [256];
    logic [16:0] exp_q [$];
    logic [15:0] wlog [6];
    int          wr_cnt;
    int          checks;
    int          errors;

    // Synchronous-read S memory; init_req plays the role of the upstream init stage.
    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (bus.wren) begin
            mem[bus.addr] <= bus.wrdata;
        end
        bus.rddata <= mem[bus.addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_identity();
        for (int k = 0; k < 256; k++) gs[k] = 8'(k);
    endtask

    task automatic push_golden(input logic [23:0] k);
        int         jj;
        logic [7:0] si;
        logic [7:0] sj;
        logic [7:0] kb;
        jj = 0;
        for (int i = 0; i < 256; i++) begin
            kb = 8'((k >> (8 * (2 - (i % 3)))) & 24'hFF);
            jj = (jj + int'(gs[i]) + int'(kb)) % 256;
            si = gs[i];
            sj = gs[jj];
            exp_q.push_back({1'b0, 8'(i), sj});
            exp_q.push_back({1'b0, 8'(jj), si});
            gs[i]  = sj;
            gs[jj] = si;
        end
    endtask

    task automatic init_mem();
        init_req = 1'b1;
        @(posedge clk); #1;
        init_req = 1'b0;
        set_identity();
    endtask

    function automatic int sbox_diff();
        int n;
        n = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== gs[k]) n++;
        return n;
    endfunction

    function automatic int perm_dups();
        logic seen [256];
        int   n;
        n = 0;
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        for (int k = 0; k < 256; k++) begin
            if (seen[mem[k]]) n++;
            seen[mem[k]] = 1'b1;
        end
        return n;
    endfunction

    // Called #1 after an edge; returns the number of cycles rdy stayed low.
    task automatic do_run(input logic [23:0] k, input int p1, input int p2,
                          input int rst_at, output int cyc);
        bus.key = k;
        bus.en  = 1'b1;
        push_golden(k);
        @(posedge clk); #1;
        bus.en  = 1'b0;
        bus.key = 24'hABCDEF;
        cyc = 0;
        while (bus.rdy == 1'b0 && cyc < 3000) begin
            cyc++;
            bus.en = (cyc == p1 || cyc == p2);
            rst_n  = (cyc != rst_at);
            @(posedge clk); #1;
        end
        bus.en = 1'b0;
        rst_n  = 1'b1;
    endtask

    initial begin
        int          cyc;
        int          snap;
        logic [15:0] t_first [6];
        t_first = '{16'h0000, 16'h0000, 16'h0104, 16'h0401, 16'h0242, 16'h4202};
        checks   = 0;
        errors   = 0;
        wr_cnt   = 0;
        mon_on   = 1'b0;
        init_req = 1'b0;
        rst_n    = 1'b0;
        bus.en   = 1'b1;
        bus.key  = 24'h00033C;

        fork
            forever begin
                logic [16:0] e;
                @(negedge clk);
                if (mon_on && bus.wren) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1_0000;
                    chk("wr_addr_data", {15'd0, 1'b0, bus.addr, bus.wrdata}, {15'd0, e});
                    if (wr_cnt < 6) wlog[wr_cnt] = {bus.addr, bus.wrdata};
                    wr_cnt++;
                end
            end
        join_none

        // Reset with en held high.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdy",  32'(bus.rdy),  32'd1);
        chk("rst_wren", 32'(bus.wren), 32'd0);
        chk("rst_addr", 32'(bus.addr), 32'd0);
        rst_n  = 1'b1;
        bus.en = 1'b0;
        mon_on = 1'b1;
        @(posedge clk); #1;
        chk("rst_en_ignored", 32'(bus.rdy), 32'd1);

        // Key 00033C, full run.
        init_mem();
        wr_cnt = 0;
        do_run(24'h00033C, 0, 0, 0, cyc);
        chk("lat_033c", 32'(cyc), 32'd1536);
        chk("nwr_033c", 32'(wr_cnt), 32'd512);
        for (int n = 0; n < 6; n++) chk("first_writes", 32'(wlog[n]), 32'(t_first[n]));
        chk("sbox_033c", 32'(sbox_diff()), 32'd0);
        chk("perm_033c", 32'(perm_dups()), 32'd0);
        chk("queue_033c", 32'(exp_q.size()), 32'd0);

        // en pulses while busy must not restart the run.
        init_mem();
        do_run(24'h00033C, 10, 700, 0, cyc);
        chk("lat_en_busy", 32'(cyc), 32'd1536);
        chk("sbox_en_busy", 32'(sbox_diff()), 32'd0);

        // Reset mid-run aborts with no further writes; then re-init and run key 0.
        init_mem();
        do_run(24'h123456, 0, 0, 800, cyc);
        chk("abort_cyc", 32'(cyc), 32'd800);
        chk("abort_rdy", 32'(bus.rdy), 32'd1);
        chk("abort_wren", 32'(bus.wren), 32'd0);
        exp_q.delete();
        snap = wr_cnt;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_wr", 32'(wr_cnt), 32'(snap));
        init_mem();
        do_run(24'h000000, 0, 0, 0, cyc);
        chk("lat_key0", 32'(cyc), 32'd1536);
        chk("sbox_key0", 32'(sbox_diff()), 32'd0);

        // All-ones key, then a back-to-back run starting in the first rdy cycle.
        init_mem();
        wr_cnt = 0;
        do_run(24'hFFFFFF, 0, 0, 0, cyc);
        chk("lat_ffffff", 32'(cyc), 32'd1536);
        chk("sbox_ffffff", 32'(sbox_diff()), 32'd0);
        do_run(24'h0A0B0C, 0, 0, 0, cyc);
        chk("lat_b2b", 32'(cyc), 32'd1536);
        chk("nwr_b2b", 32'(wr_cnt), 32'd1024);
        chk("sbox_b2b", 32'(sbox_diff()), 32'd0);
        chk("perm_b2b", 32'(perm_dups()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
